// File: rtl/map_ram_arbiter.sv
// map_ram_arbiter: shares the single map RAM port among NUM_REQ requesters.
// A two-state FSM takes one command in IDLE and issues it in ISSUE. Winners
// are picked round-robin. Reads return one cycle after issue with a requester
// tag. A saturating counter tracks issued clear (write) commands.
//
// Optional build macro: MAP_ARB_VIDEO_PRIO_EN
//   defined   : requester 0 (video renderer) wins whenever it requests; such a
//               grant leaves the round-robin pointer untouched.
//   undefined : pure round-robin over all requesters.
module map_ram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_req_write,
  input  logic [NUM_REQ*6-1:0] i_req_x,
  input  logic [NUM_REQ*5-1:0] i_req_y,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic                 o_rvalid,
  output logic [IDW-1:0]       o_rid,
  output logic                 o_rdata,
  output logic                 o_ram_en,
  output logic                 o_ram_write,
  output logic [5:0]           o_ram_tile_x,
  output logic [4:0]           o_ram_tile_y,
  input  logic                 i_ram_tile_value,
  output logic [15:0]          o_clear_count,
  output logic                 o_busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t               state_r;
  logic [IDW-1:0]       rr_ptr_r;
  logic [IDW-1:0]       grant_id_r;
  logic [NUM_REQ-1:0]   ack_r;
  logic                 ram_en_r;
  logic                 ram_write_r;
  logic [5:0]           ram_x_r;
  logic [4:0]           ram_y_r;
  logic                 busy_r;
  logic                 rvalid_r;
  logic [IDW-1:0]       rid_r;
  logic [15:0]          clear_count_r;

  logic                 any_req_s;
  logic                 rr_found_s;
  logic [IDW-1:0]       rr_win_s;
  logic [IDW-1:0]       rr_next_s;
  logic [IDW-1:0]       win_s;
  logic [IDW-1:0]       ptr_next_s;
  logic [NUM_REQ-1:0]   win_onehot_s;
  logic                 win_write_s;
  logic [5:0]           win_x_s;
  logic [4:0]           win_y_s;
  logic [15:0]          clear_count_next_s;

  assign any_req_s = |i_req;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    int cand_v;
    int next_v;
    cand_v     = 0;
    next_v     = 0;
    rr_found_s = 1'b0;
    rr_win_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_v = int'(rr_ptr_r) + k;
      if (cand_v >= NUM_REQ) begin
        cand_v = cand_v - NUM_REQ;
      end else begin
        cand_v = cand_v;
      end
      if (!rr_found_s && i_req[cand_v[IDW-1:0]]) begin
        rr_found_s = 1'b1;
        rr_win_s   = cand_v[IDW-1:0];
      end else begin
        rr_found_s = rr_found_s;
      end
    end
    next_v = int'(rr_win_s) + 1;
    if (next_v >= NUM_REQ) begin
      next_v = 0;
    end else begin
      next_v = next_v;
    end
    rr_next_s = next_v[IDW-1:0];
  end

  // Final winner and pointer update, with optional video-port priority.
  always_comb begin
`ifdef MAP_ARB_VIDEO_PRIO_EN
    if (i_req[0]) begin
      win_s      = '0;
      ptr_next_s = rr_ptr_r;
    end else begin
      win_s      = rr_win_s;
      ptr_next_s = rr_next_s;
    end
`else
    win_s      = rr_win_s;
    ptr_next_s = rr_next_s;
`endif
  end

  // Select the winning requester's command fields and build its ack mask.
  always_comb begin
    win_onehot_s = '0;
    win_write_s  = 1'b0;
    win_x_s      = 6'd0;
    win_y_s      = 5'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_s == IDW'(i)) begin
        win_onehot_s[i] = 1'b1;
        win_write_s     = i_req_write[i];
        win_x_s         = i_req_x[6*i +: 6];
        win_y_s         = i_req_y[5*i +: 5];
      end else begin
        win_onehot_s[i] = 1'b0;
      end
    end
  end

  // Control FSM: latch a command in IDLE, present it for one cycle in ISSUE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      grant_id_r  <= '0;
      ack_r       <= '0;
      ram_en_r    <= 1'b0;
      ram_write_r <= 1'b0;
      ram_x_r     <= 6'd0;
      ram_y_r     <= 5'd0;
      busy_r      <= 1'b0;
      rvalid_r    <= 1'b0;
      rid_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rvalid_r <= 1'b0;
          rid_r    <= '0;
          if (any_req_s) begin
            state_r     <= ST_ISSUE;
            rr_ptr_r    <= ptr_next_s;
            grant_id_r  <= win_s;
            ack_r       <= win_onehot_s;
            ram_en_r    <= 1'b1;
            ram_write_r <= win_write_s;
            ram_x_r     <= win_x_s;
            ram_y_r     <= win_y_s;
            busy_r      <= 1'b1;
          end else begin
            state_r     <= ST_IDLE;
            ack_r       <= '0;
            ram_en_r    <= 1'b0;
            ram_write_r <= 1'b0;
            ram_x_r     <= 6'd0;
            ram_y_r     <= 5'd0;
            busy_r      <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // The RAM read output is valid the cycle after a read is issued.
          state_r     <= ST_IDLE;
          ack_r       <= '0;
          ram_en_r    <= 1'b0;
          ram_write_r <= 1'b0;
          ram_x_r     <= 6'd0;
          ram_y_r     <= 5'd0;
          busy_r      <= 1'b0;
          rvalid_r    <= ~ram_write_r;
          rid_r       <= ram_write_r ? '0 : grant_id_r;
        end
        default: begin
          state_r     <= ST_IDLE;
          ack_r       <= '0;
          ram_en_r    <= 1'b0;
          ram_write_r <= 1'b0;
          ram_x_r     <= 6'd0;
          ram_y_r     <= 5'd0;
          busy_r      <= 1'b0;
          rvalid_r    <= 1'b0;
          rid_r       <= '0;
        end
      endcase
    end
  end

  // Saturating increment for every write presented during ISSUE.
  always_comb begin
    if ((state_r == ST_ISSUE) && ram_write_r && (clear_count_r != 16'hFFFF)) begin
      clear_count_next_s = clear_count_r + 16'd1;
    end else begin
      clear_count_next_s = clear_count_r;
    end
  end

  // Clear-count register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clear_count_r <= 16'd0;
    end else begin
      clear_count_r <= clear_count_next_s;
    end
  end

  assign o_ack         = ack_r;
  assign o_rvalid      = rvalid_r;
  assign o_rid         = rid_r;
  // Read data comes straight from the RAM's registered output, gated by valid.
  assign o_rdata       = rvalid_r & i_ram_tile_value;
  assign o_ram_en      = ram_en_r;
  assign o_ram_write   = ram_write_r;
  assign o_ram_tile_x  = ram_x_r;
  assign o_ram_tile_y  = ram_y_r;
  assign o_clear_count = clear_count_r;
  assign o_busy        = busy_r;

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Testbench for map_ram_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_map_ram_arbiter;
  localparam int NUM_REQ = 3;
  localparam int IDW     = $clog2(NUM_REQ);

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic [NUM_REQ-1:0]   i_req;
  logic [NUM_REQ-1:0]   i_req_write;
  logic [NUM_REQ*6-1:0] i_req_x;
  logic [NUM_REQ*5-1:0] i_req_y;
  logic [NUM_REQ-1:0]   o_ack;
  logic                 o_rvalid;
  logic [IDW-1:0]       o_rid;
  logic                 o_rdata;
  logic                 o_ram_en;
  logic                 o_ram_write;
  logic [5:0]           o_ram_tile_x;
  logic [4:0]           o_ram_tile_y;
  logic                 i_ram_tile_value;
  logic [15:0]          o_clear_count;
  logic                 o_busy;

  map_ram_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_req_write(i_req_write),
    .i_req_x(i_req_x), .i_req_y(i_req_y), .o_ack(o_ack), .o_rvalid(o_rvalid),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_ram_en(o_ram_en),
    .o_ram_write(o_ram_write), .o_ram_tile_x(o_ram_tile_x),
    .o_ram_tile_y(o_ram_tile_y), .i_ram_tile_value(i_ram_tile_value),
    .o_clear_count(o_clear_count), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus state per requester
  bit rq_on[NUM_REQ];
  bit rq_wr[NUM_REQ];
  int rq_x[NUM_REQ];
  int rq_y[NUM_REQ];
  bit ram_val;
  bit rst_v;
  bit prev_en;

  // Reference model: one outstanding command, tracked as a transaction
  int m_ptr;
  bit m_busy;
  int m_win;
  bit m_wr;
  int m_x;
  int m_y;
  bit m_rvalid;
  int m_rid;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      i_req[i]          = rq_on[i];
      i_req_write[i]    = rq_wr[i];
      i_req_x[6*i +: 6] = 6'(rq_x[i]);
      i_req_y[5*i +: 5] = 5'(rq_y[i]);
    end
    i_ram_tile_value = ram_val;
    i_rst            = rst_v;
  endtask

  task automatic new_cmd(input int i);
    rq_on[i] = 1'b1;
    rq_wr[i] = 1'($urandom_range(1, 0));
    rq_x[i]  = int'($urandom_range(63, 0));
    rq_y[i]  = int'($urandom_range(31, 0));
  endtask

  // Advance the model across one clock edge using the inputs present at it.
  task automatic model_edge();
    int win;
    bit prio;
    win  = -1;
    prio = 1'b0;
    if (rst_v) begin
      m_ptr = 0; m_busy = 1'b0; m_rvalid = 1'b0; m_rid = 0; m_cnt = 0;
    end else if (m_busy) begin
      m_busy   = 1'b0;
      m_rvalid = !m_wr;
      m_rid    = m_win;
      if (m_wr && m_cnt < 65535) m_cnt++;
    end else begin
      m_rvalid = 1'b0;
`ifdef MAP_ARB_VIDEO_PRIO_EN
      if (rq_on[0]) begin
        win  = 0;
        prio = 1'b1;
      end
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        if (win < 0 && rq_on[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
      end
      if (win >= 0) begin
        if (!prio) m_ptr = (win + 1) % NUM_REQ;
        m_busy = 1'b1;
        m_win  = win;
        m_wr   = rq_wr[win];
        m_x    = rq_x[win];
        m_y    = rq_y[win];
      end
    end
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_edge();
    #1;
    check("ack", 32'(o_ack), m_busy ? (32'd1 << m_win) : 32'd0);
    check("ram_en", 32'(o_ram_en), 32'(m_busy));
    check("ram_write", 32'(o_ram_write), 32'(m_busy & m_wr));
    check("ram_x", 32'(o_ram_tile_x), m_busy ? 32'(m_x) : 32'd0);
    check("ram_y", 32'(o_ram_tile_y), m_busy ? 32'(m_y) : 32'd0);
    check("busy", 32'(o_busy), 32'(m_busy));
    check("rvalid", 32'(o_rvalid), 32'(m_rvalid));
    if (m_rvalid) check("rid", 32'(o_rid), 32'(m_rid));
    check("rdata", 32'(o_rdata), 32'(m_rvalid & ram_val));
    check("clear_count", 32'(o_clear_count), 32'(m_cnt));
    check("en_b2b", 32'(o_ram_en & prev_en), 32'd0);
    prev_en = o_ram_en;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    drive();
    cycle();
    cycle();
    rst_v = 1'b0;
    drive();
  endtask

  initial begin
    int n;
    for (int i = 0; i < NUM_REQ; i++) begin
      rq_on[i] = 1'b0; rq_wr[i] = 1'b0; rq_x[i] = 0; rq_y[i] = 0;
    end
    ram_val = 1'b1; rst_v = 1'b1; prev_en = 1'b0;
    m_ptr = 0; m_busy = 1'b0; m_win = 0; m_wr = 1'b0; m_x = 0; m_y = 0;
    m_rvalid = 1'b0; m_rid = 0; m_cnt = 0;

    // Reset and single read
    do_reset();
    check("rst_ack", 32'(o_ack), 32'd0);
    check("rst_cnt", 32'(o_clear_count), 32'd0);
    rq_on[1] = 1'b1; rq_wr[1] = 1'b0; rq_x[1] = 5; rq_y[1] = 3;
    drive();
    cycle();
    check("rd_ack", 32'(o_ack), 32'b010);
    check("rd_en", 32'(o_ram_en), 32'd1);
    check("rd_x", 32'(o_ram_tile_x), 32'd5);
    check("rd_y", 32'(o_ram_tile_y), 32'd3);
    rq_on[1] = 1'b0;
    drive();
    cycle();
    check("rd_rvalid", 32'(o_rvalid), 32'd1);
    check("rd_rid", 32'(o_rid), 32'd1);
    check("rd_rdata", 32'(o_rdata), 32'd1);
    ram_val = 1'b0;
    drive();
    #1;
    check("rd_rdata_pass", 32'(o_rdata), 32'd0);
    cycle();

    // Arbitration with all three requesting reads
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      rq_on[i] = 1'b1; rq_wr[i] = 1'b0; rq_x[i] = 10 + i; rq_y[i] = 20 + i;
    end
    drive();
    n = 0;
`ifdef MAP_ARB_VIDEO_PRIO_EN
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (o_ack != '0) begin
        check("prio_ack", 32'(o_ack), 32'b001);
        n++;
      end
    end
    check("prio_count", 32'(n), 32'd3);
    rq_on[0] = 1'b0;
    drive();
    n = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (o_ack != '0) begin
        check("prio_rr_ack", 32'(o_ack), (n % 2 == 0) ? 32'b010 : 32'b100);
        n++;
      end
    end
    check("prio_rr_count", 32'(n), 32'd4);
`else
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (o_ack != '0) begin
        check("rr_ack", 32'(o_ack), 32'd1 << (n % 3));
        n++;
      end
    end
    check("rr_count", 32'(n), 32'd6);
`endif
    for (int i = 0; i < NUM_REQ; i++) rq_on[i] = 1'b0;
    drive();
    cycle();
    cycle();

    // Clear counting and saturation
    do_reset();
    rq_on[2] = 1'b1; rq_wr[2] = 1'b1; rq_x[2] = 7; rq_y[2] = 9;
    drive();
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("clr_no_rvalid", 32'(o_rvalid), 32'd0);
    end
    rq_on[2] = 1'b0;
    drive();
    cycle();
    check("clr_count5", 32'(o_clear_count), 32'd5);
    force dut.clear_count_r = 16'hFFFE;
    m_cnt = 65534;
    cycle();
    release dut.clear_count_r;
    rq_on[2] = 1'b1;
    drive();
    for (int c = 0; c < 6; c++) cycle();
    rq_on[2] = 1'b0;
    drive();
    cycle();
    check("clr_sat", 32'(o_clear_count), 32'h0000FFFF);

    // Reset during an ISSUE read
    do_reset();
    rq_on[1] = 1'b1; rq_wr[1] = 1'b0; rq_x[1] = 1; rq_y[1] = 2;
    drive();
    cycle();
    check("mid_ack", 32'(o_ack), 32'b010);
    rq_on[1] = 1'b0; rst_v = 1'b1; ram_val = 1'b1;
    drive();
    cycle();
    check("mid_rvalid", 32'(o_rvalid), 32'd0);
    check("mid_rdata", 32'(o_rdata), 32'd0);
    check("mid_rid", 32'(o_rid), 32'd0);
    check("mid_en", 32'(o_ram_en), 32'd0);
    check("mid_busy", 32'(o_busy), 32'd0);
    check("mid_ptr", 32'(dut.rr_ptr_r), 32'd0);
    rst_v = 1'b0; rq_on[2] = 1'b1; rq_wr[2] = 1'b0;
    drive();
    cycle();
    check("mid_grant2", 32'(o_ack), 32'b100);
    rq_on[2] = 1'b0;
    drive();
    cycle();
    cycle();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_busy && m_win == i && rq_on[i]) begin
          if ($urandom_range(1, 0) == 0) rq_on[i] = 1'b0;
          else new_cmd(i);
        end else if (!rq_on[i] && $urandom_range(3, 0) == 0) begin
          new_cmd(i);
        end
      end
      rst_v   = ($urandom_range(63, 0) == 0);
      ram_val = 1'($urandom_range(1, 0));
      drive();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
